// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/flush/write-enable arbitration with HLT drain and halt.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic        halt_dec,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int unsigned CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t          state, state_nxt;
  logic            redirect_pending, redirect_nxt;
  logic [CW-1:0]   drain_cnt, drain_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      redirect_pending <= 1'b0;
      drain_cnt        <= '0;
    end else begin
      state            <= state_nxt;
      redirect_pending <= redirect_nxt;
      drain_cnt        <= drain_nxt;
    end
  end

  // Drain counts non-frozen cycles; the cycle that takes it to zero is the last DRAIN cycle.
  always_comb begin
    state_nxt    = state;
    redirect_nxt = redirect_pending;
    drain_nxt    = drain_cnt;
    case (state)
      RUN: begin
        if (dmem_busy || hazard_stall) begin
          state_nxt = RUN;
        end else if (halt_dec) begin
          state_nxt    = DRAIN;
          drain_nxt    = CW'(DRAIN_CYCLES);
          redirect_nxt = 1'b0;
        end else if (branch_taken) begin
          redirect_nxt = imem_busy;
        end else if (redirect_pending && !imem_busy) begin
          redirect_nxt = 1'b0;
        end
      end
      DRAIN: begin
        if (!dmem_busy) begin
          redirect_nxt = 1'b0;
          if (drain_cnt <= CW'(1)) state_nxt = HALT;
          if (drain_cnt != '0) drain_nxt = drain_cnt - CW'(1);
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    id_ex_we    = 1'b1;
    ex_mem_we   = 1'b1;
    mem_wb_we   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = '0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state == HALT) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = '0;
      halted = 1'b1;
    end else if (dmem_busy) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = '0;
    end else if (state == DRAIN) begin
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
    end else if (hazard_stall) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (halt_dec) begin
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
    end else if (redirect_pending || imem_busy) begin
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (state == RUN && !pc_we && stall_q != '1) stall_q <= stall_q + 16'd1;
      if ((if_id_flush || id_ex_flush) && flush_q != '1) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic
// against a behavioural model of the control rules.
module tb_pipe_ctrl;

  localparam int unsigned DC = 3;

  logic        clk = 1'b0;
  logic        rst, hazard_stall, branch_taken, halt_dec, imem_busy, dmem_busy;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  bit m_halted, m_drain, m_redir;
  int m_left;
  int m_stall, m_flush;
  bit obs_halted;
  bit [6:0] obs_vec;

  pipe_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
    .halt_dec(halt_dec), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs just after a rising edge, check mid-cycle, then advance.
  task automatic step(input bit r, input bit hs, input bit bt, input bit hd,
                      input bit ib, input bit db);
    bit [6:0] e;  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    bit       eh;
    rst = r; hazard_stall = hs; branch_taken = bt; halt_dec = hd;
    imem_busy = ib; dmem_busy = db;
    eh = 1'b0;
    if (r)                   e = 7'b0000011;
    else if (m_halted)       begin e = 7'b0000000; eh = 1'b1; end
    else if (db)             e = 7'b0000000;
    else if (m_drain)        e = 7'b0111110;
    else if (hs)             e = 7'b0011101;
    else if (hd)             e = 7'b0111110;
    else if (bt)             e = 7'b1111110;
    else if (m_redir || ib)  e = 7'b0111110;
    else                     e = 7'b1111100;
    #3;
    obs_vec    = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush};
    obs_halted = halted;
    chk("ctrl_vec", {9'd0, obs_vec}, {9'd0, e});
    chk("halted", {15'd0, obs_halted}, {15'd0, eh});
    chk("stall_cnt", stall_cnt, m_stall[15:0]);
    chk("flush_cnt", flush_cnt, m_flush[15:0]);
`ifdef PIPE_PERF_CNT_EN
    if (r) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (!m_drain && !m_halted && !e[6] && m_stall < 65535) m_stall++;
      if ((e[1] || e[0]) && m_flush < 65535) m_flush++;
    end
`endif
    if (r) begin
      m_halted = 0; m_drain = 0; m_redir = 0; m_left = 0;
    end else if (m_halted || db || (!m_drain && hs)) begin
      // frozen or stalled: no control state moves
    end else if (m_drain) begin
      m_redir = 0;
      m_left--;
      if (m_left <= 0) begin m_drain = 0; m_halted = 1; end
    end else if (hd) begin
      m_drain = 1; m_left = (DC == 0) ? 1 : DC; m_redir = 0;
    end else if (bt) begin
      m_redir = ib;
    end else if (m_redir && !ib) begin
      m_redir = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int flushes;
    int rise_at;
    rst = 1'b1; hazard_stall = 0; branch_taken = 0; halt_dec = 0; imem_busy = 0; dmem_busy = 0;
    m_halted = 0; m_drain = 0; m_redir = 0; m_left = 0; m_stall = 0; m_flush = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // single-cycle load-use stall, then free running
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // branch into a busy fetch: four flushed cycles in a row
    flushes = 0;
    step(0, 0, 1, 0, 1, 0); flushes += obs_vec[1];
    step(0, 0, 0, 0, 1, 0); flushes += obs_vec[1];
    step(0, 0, 0, 0, 1, 0); flushes += obs_vec[1];
    step(0, 0, 0, 0, 0, 0); flushes += obs_vec[1];
    chk("redirect_flush_run", flushes[15:0], 16'd4);
    step(0, 0, 0, 0, 0, 0);
    chk("redirect_cleared_pc_we", {15'd0, obs_vec[6]}, 16'd1);

    // dmem_busy freezes everything, stall applies once it drops
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // HLT with a two-cycle dmem freeze in the second drain cycle
    rise_at = -1;
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 4; i < 20; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (obs_halted && rise_at < 0) rise_at = i;
    end
    chk("halt_latency", rise_at[15:0], 16'd6);
    chk("halt_sticky", {15'd0, obs_halted}, 16'd1);

    // reset pulse during HALT, then normal run
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("post_reset_pc_we", {15'd0, obs_vec[6]}, 16'd1);
    step(0, 0, 0, 0, 1, 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(59, 0) == 0,
           $urandom_range(3, 0) == 0,
           $urandom_range(3, 0) == 0,
           $urandom_range(39, 0) == 0,
           $urandom_range(2, 0) == 0,
           $urandom_range(4, 0) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, 3, cycles after HLT leaves ID before the core is declared halted.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 hazard_stall  input  1  load-use stall request from the hazard detection unit.
REQ-005 branch_taken  input  1  branch/jump in ID resolved taken this cycle.
REQ-006 halt_dec  input  1  HLT (opcode 4'b1111) decoded in ID.
REQ-007 imem_busy  input  1  instruction fetch outstanding, IF output invalid.
REQ-008 dmem_busy  input  1  data access in MEM not complete.
REQ-009 pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  output  1 each  PC and pipeline-register write enables.
REQ-010 if_id_flush, id_ex_flush  output  1 each  load NOP bubble into IF/ID or ID/EX.
REQ-011 halted  output  1  core stopped, all stages retired.
REQ-012 stall_cnt, flush_cnt  output  16 each  performance counters.

Function
REQ-013 States: RUN, DRAIN, HALT; plus 1-bit redirect_pending flag and a drain counter of width clog2(DRAIN_CYCLES+1).
REQ-014 Decision priority within a cycle: dmem_busy > hazard_stall > halt_dec > branch_taken > imem_busy.
REQ-015 Default (RUN, no request): all five enables 1, both flushes 0.
REQ-016 dmem_busy=1 in RUN or DRAIN: all enables 0, flushes 0, no state/flag/drain-counter change; all other inputs ignored.
REQ-017 hazard_stall=1: pc_we=0, if_id_we=0, id_ex_flush=1, other enables 1; branch_taken and halt_dec ignored that cycle.
REQ-018 branch_taken=1 (RUN): pc_we=1, if_id_flush=1; if imem_busy=1 that same cycle, set redirect_pending.
REQ-019 imem_busy=1, no higher request: pc_we=0, if_id_flush=1, downstream enables 1.
REQ-020 redirect_pending=1: if_id_flush=1 every cycle while imem_busy=1 and on the first cycle imem_busy=0, then clears; pc_we=0 during that time unless a new branch_taken.
REQ-021 halt_dec=1 in RUN: pc_we=0, if_id_flush=1, next state DRAIN, drain counter loaded with DRAIN_CYCLES.
REQ-022 DRAIN: pc_we=0, if_id_flush=1, downstream enables 1; counter decrements each non-frozen cycle; at 0 next state HALT.
REQ-023 DRAIN ignores hazard_stall, branch_taken, halt_dec, imem_busy; clears redirect_pending.
REQ-024 HALT: all enables 0, flushes 0, halted=1, exits only on rst.
REQ-025 halted=0 in RUN and DRAIN.
REQ-026 Outputs are combinational from state and inputs; no added latency.

Reset
REQ-027 rst=1 at a clock edge: state RUN, redirect_pending 0, drain counter 0, counters 0.
REQ-028 While rst=1: all enables 0, both flushes 1, halted 0.
REQ-029 rst overrides every condition, including mid-DRAIN and HALT; first cycle after release behaves as RUN.

Configuration
REQ-030 PIPE_PERF_CNT_EN defined: stall_cnt increments each cycle pc_we=0 in RUN; flush_cnt increments each cycle either flush=1; both saturate at 16'hFFFF.
REQ-031 PIPE_PERF_CNT_EN undefined: no counter registers; stall_cnt and flush_cnt tied to 16'h0000.

Verification
REQ-032 RUN, hazard_stall=1 one cycle -> pc_we=0, if_id_we=0, id_ex_flush=1, next cycle all enables 1.
REQ-033 branch_taken=1 with imem_busy=1 for 3 cycles -> if_id_flush=1 for 4 consecutive cycles, redirect_pending clears after the 4th.
REQ-034 halt_dec=1, dmem_busy=1 on 2nd DRAIN cycle for 2 cycles -> halted rises 6 cycles after halt_dec (DRAIN_CYCLES=3), stays 1.
REQ-035 dmem_busy=1 with hazard_stall=1 and branch_taken=1 -> all enables 0, flushes 0; stall applied the cycle dmem_busy drops.
REQ-036 rst pulse during HALT -> halted=0, enables 1 first cycle after release; with PIPE_PERF_CNT_EN, counters read 0 then count from 1.
